// File: rtl/ifft_output_conjugate_scaler.sv
// ifft_output_conjugate_scaler
//
// Post-processor for the output of the SDF FFT. Together with the conjugate on
// the input side it implements IFFT(x) = conj(FFT(conj(x))) / N.
//
// Per-frame mode:
//   mode = 0 : FFT passthrough. The data is registered twice and not changed.
//   mode = 1 : IFFT. Stage 1 conjugates each sample (saturating negate of the
//              imaginary part). Stage 2 scales by 1/N with round-half-up.
// The latency is 2 cycles in both modes, so downstream timing does not depend
// on the mode.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   mode_in    : 0 = FFT, 1 = IFFT; sampled on the first valid sample of a frame
//   valid_in   : data_in_r / data_in_i valid this cycle
//   data_in_r  : signed real part from the FFT
//   data_in_i  : signed imaginary part from the FFT
//   valid_out  : output sample valid
//   data_out_r : signed real result (holds its value when valid_out = 0)
//   data_out_i : signed imaginary result (holds its value when valid_out = 0)
//   sop_out    : high with valid_out on sample index 0 of a frame
//   eop_out    : high with valid_out on sample index N_POINTS-1
//   mode_out   : mode applied to the current output frame
module ifft_output_conjugate_scaler #(
    parameter int DATA_WIDTH = 32,
    parameter int N_POINTS   = 64,
    parameter int LOG2_N     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode_in,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in_r,
    input  logic signed [DATA_WIDTH-1:0] data_in_i,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out_r,
    output logic signed [DATA_WIDTH-1:0] data_out_i,
    output logic                         sop_out,
    output logic                         eop_out,
    output logic                         mode_out
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    // Rounding offset 2^(LOG2_N-1), held in the widened arithmetic width.
    localparam logic signed [DATA_WIDTH:0] ROUND_OFS =
        (DATA_WIDTH+1)'(1) <<< (LOG2_N - 1);

    // ------------------------------------------------------------------
    // Sample counter and per-frame mode latch
    // ------------------------------------------------------------------
    logic [LOG2_N-1:0] count_reg, count_next;
    logic              mode_latch_reg, mode_latch_next;
    logic              frame_start;
    logic              eff_mode;

    assign frame_start = (count_reg == '0);
    // The first sample of a frame uses mode_in directly. The latched copy is
    // only visible from the second sample onward.
    assign eff_mode = frame_start ? mode_in : mode_latch_reg;

    always_comb begin
        count_next      = count_reg;
        mode_latch_next = mode_latch_reg;
        if (valid_in) begin
            count_next = (count_reg == LAST_IDX) ? '0 : count_reg + 1'b1;
            if (frame_start) begin
                mode_latch_next = mode_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= '0;
            mode_latch_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            mode_latch_reg <= mode_latch_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: conjugate (IFFT) or pass (FFT); register index flags + mode
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] s1_data_reg [2];   // [0] real, [1] imag
    logic signed [DATA_WIDTH-1:0] s1_data_next [2];
    logic                         s1_valid_reg;
    logic                         s1_sop_reg;
    logic                         s1_eop_reg;
    logic                         s1_mode_reg;

    always_comb begin
        s1_data_next[0] = data_in_r;
        s1_data_next[1] = data_in_i;
        if (eff_mode) begin
            // Negating the most negative value would wrap, so it is clamped
            // to the largest positive value.
            s1_data_next[1] = (data_in_i == MIN_VAL) ? MAX_VAL : -data_in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_sop_reg     <= 1'b0;
            s1_eop_reg     <= 1'b0;
            s1_mode_reg    <= 1'b0;
            s1_data_reg[0] <= '0;
            s1_data_reg[1] <= '0;
        end else begin
            s1_valid_reg   <= valid_in;
            s1_sop_reg     <= frame_start;
            s1_eop_reg     <= (count_reg == LAST_IDX);
            s1_mode_reg    <= eff_mode;
            s1_data_reg[0] <= s1_data_next[0];
            s1_data_reg[1] <= s1_data_next[1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: scale by 1/N with round-half-up (IFFT) or pass (FFT)
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] s2_data_next [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_scale
            logic signed [DATA_WIDTH:0] widened;
            logic signed [DATA_WIDTH:0] shifted;
            // One extra bit absorbs the rounding offset without overflow.
            // The arithmetic shift then floors, which gives round-half-up.
            assign widened = {s1_data_reg[gi][DATA_WIDTH-1], s1_data_reg[gi]} + ROUND_OFS;
            assign shifted = widened >>> LOG2_N;
            assign s2_data_next[gi] = s1_mode_reg ? DATA_WIDTH'(shifted) : s1_data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out  <= 1'b0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
            mode_out   <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            valid_out <= s1_valid_reg;
            sop_out   <= s1_valid_reg & s1_sop_reg;
            eop_out   <= s1_valid_reg & s1_eop_reg;
            // Data and mode hold their last values between valid samples.
            if (s1_valid_reg) begin
                mode_out   <= s1_mode_reg;
                data_out_r <= s2_data_next[0];
                data_out_i <= s2_data_next[1];
            end
        end
    end

endmodule

// File: tb/tb_ifft_output_conjugate_scaler.sv
// Self-checking bench for ifft_output_conjugate_scaler. A frame-level model
// tracks sample index and per-frame mode. It computes each expected output
// with plain integer arithmetic and queues it with its due cycle. A compare
// process checks the DUT on every falling edge.
module tb_ifft_output_conjugate_scaler;

    localparam int DW = 32;
    localparam int N  = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode_in = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [DW-1:0] data_in_r = '0;
    logic signed [DW-1:0] data_in_i = '0;
    logic                 valid_out;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;
    logic                 sop_out;
    logic                 eop_out;
    logic                 mode_out;

    ifft_output_conjugate_scaler #(.DATA_WIDTH(DW), .N_POINTS(N), .LOG2_N(6)) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .valid_in(valid_in),
        .data_in_r(data_in_r), .data_in_i(data_in_i),
        .valid_out(valid_out), .data_out_r(data_out_r), .data_out_i(data_out_i),
        .sop_out(sop_out), .eop_out(eop_out), .mode_out(mode_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int     due;
        longint r;
        longint i;
        bit     sop;
        bit     eop;
        bit     mode;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     m_cnt = 0;       // model: index of next accepted sample
    bit     m_mode = 0;      // model: mode of current frame
    longint last_r = 0, last_i = 0;
    bit     last_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor division by N, written out explicitly for negative numerators.
    function automatic longint floor_div_n(input longint v);
        if (v >= 0) return v / N;
        return -((-v + N - 1) / N);
    endfunction

    function automatic longint scale(input longint v);
        return floor_div_n(v + N / 2);   // round half up
    endfunction

    // Drive one valid sample and push its expected output into the queue.
    task automatic send(input bit mode, input int r, input int i);
        exp_t   e;
        longint ni;
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        mode_in   = mode;
        data_in_r = r;
        data_in_i = i;
        if (m_cnt == 0) m_mode = mode;
        ni = -longint'(i);
        if (ni > 64'sd2147483647) ni = 64'sd2147483647;
        e.due  = cyc + 2;
        e.sop  = (m_cnt == 0);
        e.eop  = (m_cnt == N - 1);
        e.mode = m_mode;
        e.r    = m_mode ? scale(longint'(r)) : longint'(r);
        e.i    = m_mode ? scale(ni) : longint'(i);
        q.push_back(e);
        m_cnt = (m_cnt + 1) % N;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        mode_in   = $urandom_range(0, 1);
        data_in_r = $urandom;
        data_in_i = $urandom;
    endtask

    // Literal check of the output two cycles after the preceding send().
    task automatic expect_lit(input string name, input longint r, input longint i,
                              input bit sop, input bit mode);
        idle();
        @(posedge clk);
        #2;
        chk({name, "_valid"}, valid_out, 1);
        chk({name, "_r"}, data_out_r, r);
        chk({name, "_i"}, data_out_i, i);
        chk({name, "_sop"}, sop_out, sop);
        chk({name, "_mode"}, mode_out, mode);
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        valid_in = 1'b0;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_r", data_out_r, 0);
        chk("rst_i", data_out_i, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_mode", mode_out, 0);
        q.delete();
        m_cnt = 0;
        m_mode = 0;
        last_r = 0;
        last_i = 0;
        last_mode = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    function automatic int rnd_data();
        case ($urandom_range(0, 5))
            0:       return 32'sh8000_0000;
            1:       return 32'sh7FFF_FFFF;
            2:       return int'($urandom_range(0, 200)) - 100;
            default: return int'($urandom);
        endcase
    endfunction

    // Compare process: checks every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("valid", valid_out, 1);
                chk("data_r", data_out_r, e.r);
                chk("data_i", data_out_i, e.i);
                chk("sop", sop_out, e.sop);
                chk("eop", eop_out, e.eop);
                chk("mode", mode_out, e.mode);
                last_r = e.r;
                last_i = e.i;
                last_mode = e.mode;
            end else begin
                chk("idle_valid", valid_out, 0);
                chk("idle_sop", sop_out, 0);
                chk("idle_eop", eop_out, 0);
                chk("hold_r", data_out_r, last_r);
                chk("hold_i", data_out_i, last_i);
                chk("hold_mode", mode_out, last_mode);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", valid_out, 0);
        chk("init_r", data_out_r, 0);
        chk("init_mode", mode_out, 0);
        #2;
        rst = 1'b0;

        // IFFT frame: first sample, rounding, saturation; mode_in=0 mid-frame ignored.
        send(1, 640, -320);        expect_lit("first", 10, 5, 1, 1);
        send(0, 32, 0);            expect_lit("rnd32", 1, 0, 0, 1);
        send(0, 31, 0);            expect_lit("rnd31", 0, 0, 0, 1);
        send(0, -32, 0);           expect_lit("rndm32", 0, 0, 0, 1);
        send(0, -33, 0);           expect_lit("rndm33", -1, 0, 0, 1);
        send(0, 32'sh7FFF_FFFF, 32'sh8000_0000);
        expect_lit("sat", 33554432, 33554432, 0, 1);
        do send(0, rnd_data(), rnd_data()); while (m_cnt != 0);

        // FFT frame with random gaps.
        for (int s = 0; s < N; s++) begin
            send(0, rnd_data(), rnd_data());
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
        end

        // mode_in toggles at sample 10: whole frame stays FFT; next frame IFFT
        // (back to back with the previous frame).
        for (int s = 0; s < N; s++) send(s >= 10, rnd_data(), rnd_data());
        for (int s = 0; s < N; s++) send(1, rnd_data(), rnd_data());

        // Reset during sample 30 with samples in flight.
        for (int s = 0; s <= 30; s++) send(0, rnd_data(), rnd_data());
        do_reset();
        send(1, 640, -320);        expect_lit("post_rst", 10, 5, 1, 1);
        do send(1, rnd_data(), rnd_data()); while (m_cnt != 0);

        // Random frames with random modes and gaps.
        for (int f = 0; f < 4; f++) begin
            bit fm;
            fm = $urandom_range(0, 1);
            for (int s = 0; s < N; s++) begin
                send(s == 0 ? fm : bit'($urandom_range(0, 1)), rnd_data(), rnd_data());
                if ($urandom_range(0, 3) == 0) idle();
            end
        end

        repeat (4) idle();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
